// File: rtl/debug_pkg.sv
// Shared constants for the MIPS debug-dump receiver: command byte, FSM encoding, sizing helpers.
package debug_pkg;

   localparam logic [7:0] CMD_STEP = 8'h73;

   localparam int unsigned STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
   localparam logic [STATE_W-1:0] ST_SEND_CMD = 2'd1;
   localparam logic [STATE_W-1:0] ST_COLLECT  = 2'd2;
   localparam logic [STATE_W-1:0] ST_DONE     = 2'd3;

   // DUMP_WORDS: PC + register file + ALU result
   function automatic int unsigned dump_words(input int unsigned number_registers);
      return number_registers + 2;
   endfunction

   // BYTES_PER_WORD
   function automatic int unsigned bytes_per_word(input int unsigned nb, input int unsigned data_bits);
      return nb / data_bits;
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects UART bytes MSB-first into NB-bit words; flags the byte that completes a word.
module word_assembler
   import debug_pkg::*;
#(
   parameter int unsigned NB        = 32,
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [DATA_BITS-1:0] i_byte,
   input  logic                 i_byte_valid,
   input  logic                 i_clear,
   output logic [NB-1:0]        o_word_c,
   output logic                 o_word_done_c
);

   localparam int unsigned BPW = bytes_per_word(NB, DATA_BITS);
   localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;

   logic [NB-1:0]  shift_q, shift_d;
   logic [BCW-1:0] byte_cnt_q, byte_cnt_d;

   // Completed word is the shifted history plus the byte arriving this cycle.
   always_comb begin
      o_word_c      = NB'({shift_q, i_byte});
      o_word_done_c = i_byte_valid && (byte_cnt_q == BCW'(BPW - 1));
   end

   always_comb begin
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      if (i_clear) begin
         shift_d    = '0;
         byte_cnt_d = '0;
      end else if (i_byte_valid) begin
         shift_d    = o_word_c;
         byte_cnt_d = o_word_done_c ? '0 : byte_cnt_q + BCW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         shift_q    <= '0;
         byte_cnt_q <= '0;
      end else begin
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

endmodule

// File: rtl/debug_dump_receiver.sv
// Host side of the MIPS debug unit: sends a step command, then stores the PC/register/ALU dump.
module debug_dump_receiver
   import debug_pkg::*;
#(
   parameter int unsigned NB               = 32,
   parameter int unsigned DATA_BITS        = 8,
   parameter int unsigned NUMBER_REGISTERS = 32,
   parameter int unsigned TIMEOUT_CYCLES   = 1_000_000
) (
   input  logic                                   i_clk,
   input  logic                                   i_reset,
   input  logic                                   i_start,
   input  logic                                   i_uart_rx_ready,
   input  logic [DATA_BITS-1:0]                   i_uart_rx_data,
   input  logic                                   i_uart_tx_done,
   output logic [DATA_BITS-1:0]                   o_uart_tx_data,
   output logic                                   o_uart_tx_ready,
   input  logic [$clog2(NUMBER_REGISTERS+2)-1:0]  i_rd_index,
   output logic [NB-1:0]                          o_rd_word,
   output logic                                   o_busy,
   output logic                                   o_dump_valid,
   output logic                                   o_error
);

   localparam int unsigned NWORDS = dump_words(NUMBER_REGISTERS);
   localparam int unsigned IDXW   = $clog2(NWORDS);
   localparam int unsigned ICW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [STATE_W-1:0]   state_q, state_d;
   logic [IDXW-1:0]      word_cnt_q, word_cnt_d;
   logic [ICW-1:0]       idle_cnt_q, idle_cnt_d;
   logic [NB-1:0]        store_q [NWORDS];

   logic [DATA_BITS-1:0] tx_data_d;
   logic                 tx_ready_d, busy_d, dump_valid_d, error_d;

   logic                 collect_c, byte_valid_c, word_done_c, last_word_c, timeout_c;
   logic [NB-1:0]        word_c;

   // Bytes outside COLLECT are dropped; leaving COLLECT discards any partial word.
   assign collect_c    = (state_q == ST_COLLECT);
   assign byte_valid_c = collect_c & i_uart_rx_ready;
   assign last_word_c  = (word_cnt_q == IDXW'(NWORDS - 1));
   assign timeout_c    = collect_c & ~i_uart_rx_ready &
                         (idle_cnt_q == ICW'(TIMEOUT_CYCLES - 1));

   word_assembler #(
      .NB        (NB),
      .DATA_BITS (DATA_BITS)
   ) u_word_assembler (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_byte        (i_uart_rx_data),
      .i_byte_valid  (byte_valid_c),
      .i_clear       (~collect_c),
      .o_word_c      (word_c),
      .o_word_done_c (word_done_c)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (i_start) state_d = ST_SEND_CMD;
         ST_SEND_CMD: if (i_uart_tx_done) state_d = ST_COLLECT;
         ST_COLLECT: begin
            if (word_done_c && last_word_c) state_d = ST_DONE;
            else if (timeout_c)             state_d = ST_IDLE;
         end
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Outputs follow the state being entered so they line up with it.
   always_comb begin
      tx_ready_d   = (state_d == ST_SEND_CMD);
      tx_data_d    = tx_ready_d ? DATA_BITS'(CMD_STEP) : '0;
      busy_d       = (state_d != ST_IDLE);
      dump_valid_d = (state_d == ST_DONE);
      error_d      = timeout_c;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_uart_tx_data  <= '0;
         o_uart_tx_ready <= 1'b0;
         o_busy          <= 1'b0;
         o_dump_valid    <= 1'b0;
         o_error         <= 1'b0;
      end else begin
         o_uart_tx_data  <= tx_data_d;
         o_uart_tx_ready <= tx_ready_d;
         o_busy          <= busy_d;
         o_dump_valid    <= dump_valid_d;
         o_error         <= error_d;
      end
   end

   always_comb begin
      word_cnt_d = word_cnt_q;
      idle_cnt_d = idle_cnt_q;
      if (!collect_c) begin
         word_cnt_d = '0;
         idle_cnt_d = '0;
      end else begin
         if (word_done_c) word_cnt_d = word_cnt_q + IDXW'(1);
         if (i_uart_rx_ready || timeout_c) idle_cnt_d = '0;
         else                              idle_cnt_d = idle_cnt_q + ICW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         word_cnt_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int unsigned i = 0; i < NWORDS; i++) store_q[i] <= '0;
      end else if (word_done_c) begin
         store_q[word_cnt_q] <= word_c;
      end
   end

   always_comb begin
      o_rd_word = '0;
      if (32'(i_rd_index) < NWORDS) o_rd_word = store_q[i_rd_index];
   end

endmodule

// File: tb/tb_debug_dump_receiver.sv
// Randomized bench for debug_dump_receiver against a word-level model of the dump store.
`timescale 1ns/1ps
module tb_debug_dump_receiver;

   localparam int NB  = 32;
   localparam int DB  = 8;
   localparam int NR  = 5;
   localparam int TO  = 50;
   localparam int DW  = NR + 2;
   localparam int IW  = $clog2(NR + 2);
   localparam int BPW = NB / DB;
   localparam int NIDX = 1 << IW;

   logic          clk = 1'b0;
   logic          rst_n, start, rx_ready, tx_done;
   logic [DB-1:0] rx_data, tx_data;
   logic          tx_ready, busy, dump_valid, error;
   logic [IW-1:0] rd_index;
   logic [NB-1:0] rd_word;

   int vectors = 0;
   int miscompares = 0;
   int dv_cnt = 0, err_cnt = 0, cmd_cnt = 0;
   int exp_dv = 0, exp_err = 0, exp_cmd = 0;
   logic txr_prev = 1'b0;

   logic [NB-1:0] exp_store [DW];
   logic [NB-1:0] dump_w    [DW];
   logic [NB-1:0] exp_w;

   always #10 clk = ~clk;

   debug_dump_receiver #(
      .NB               (NB),
      .DATA_BITS        (DB),
      .NUMBER_REGISTERS (NR),
      .TIMEOUT_CYCLES   (TO)
   ) dut (
      .i_clk           (clk),
      .i_reset         (rst_n),
      .i_start         (start),
      .i_uart_rx_ready (rx_ready),
      .i_uart_rx_data  (rx_data),
      .i_uart_tx_done  (tx_done),
      .o_uart_tx_data  (tx_data),
      .o_uart_tx_ready (tx_ready),
      .i_rd_index      (rd_index),
      .o_rd_word       (rd_word),
      .o_busy          (busy),
      .o_dump_valid    (dump_valid),
      .o_error         (error)
   );

   // Pulse and command counters sampled mid-cycle.
   always @(negedge clk) begin
      if (dump_valid === 1'b1) dv_cnt <= dv_cnt + 1;
      if (error === 1'b1) err_cnt <= err_cnt + 1;
      if (tx_ready === 1'b1 && txr_prev !== 1'b1) cmd_cnt <= cmd_cnt + 1;
      txr_prev <= tx_ready;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [DB-1:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      rx_data  = DB'($urandom);
   endtask

   // Byte stream position i -> word i/BPW, MSB-first byte i%BPW.
   task automatic send_bytes(input int first, input int count);
      logic [NB-1:0] w;
      for (int i = first; i < first + count; i++) begin
         repeat ($urandom_range(0, 3)) step();
         w = dump_w[i / BPW];
         send_byte(DB'(w >> (NB - DB * (i % BPW + 1))));
      end
   endtask

   task automatic rand_dump();
      for (int k = 0; k < DW; k++) dump_w[k] = $urandom;
   endtask

   task automatic model_words(input int n);
      for (int k = 0; k < n; k++) exp_store[k] = dump_w[k];
   endtask

   task automatic issue_cmd();
      start = 1'b1;
      step();
      start = 1'b0;
      exp_cmd++;
      repeat ($urandom_range(0, 2)) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         start    = 1'($urandom);
         rx_ready = 1'($urandom);
         tx_done  = 1'($urandom);
         rx_data  = DB'($urandom);
         step();
      end
      start = 1'b0; rx_ready = 1'b0; tx_done = 1'b0;
      for (int k = 0; k < DW; k++) exp_store[k] = '0;
      vectors++; if (tx_data !== '0) begin miscompares++; $display("FAIL reset tx_data: got %h expected 00", tx_data); end
      vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL reset tx_ready: got %b expected 0", tx_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
      vectors++; if (dump_valid !== 1'b0) begin miscompares++; $display("FAIL reset dump_valid: got %b expected 0", dump_valid); end
      vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset error: got %b expected 0", error); end
      for (int i = 0; i < NIDX; i++) begin
         rd_index = IW'(i); #1;
         vectors++;
         if (rd_word !== '0) begin miscompares++; $display("FAIL reset rd[%0d]: got %h expected 0", i, rd_word); end
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_start_handshake();
      tx_done = 1'b1; step(); tx_done = 1'b0;
      vectors++; if (tx_ready !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_tx_done: got ready=%b busy=%b expected 0 0", tx_ready, busy); end
      start = 1'b1; step(); start = 1'b0; exp_cmd++;
      vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL start tx_ready: got %b expected 1", tx_ready); end
      vectors++; if (tx_data !== 8'h73) begin miscompares++; $display("FAIL start tx_data: got %h expected 73", tx_data); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL start busy: got %b expected 1", busy); end
      start = 1'b1; step(); start = 1'b0;
      vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL hold tx_ready: got %b expected 1", tx_ready); end
      tx_done = 1'b1; step(); tx_done = 1'b0;
      vectors++; if (tx_ready !== 1'b0 || tx_data !== '0) begin miscompares++; $display("FAIL tx_done: got ready=%b data=%h expected 0 00", tx_ready, tx_data); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL collect busy: got %b expected 1", busy); end
      start = 1'b1; step(); start = 1'b0;
      vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL busy_start tx_ready: got %b expected 0", tx_ready); end
      rand_dump();
      send_bytes(0, DW * BPW);
      exp_dv++;
      model_words(DW);
      step(); step();
      vectors++; if (cmd_cnt !== exp_cmd) begin miscompares++; $display("FAIL cmd_count: got %0d expected %0d", cmd_cnt, exp_cmd); end
      vectors++; if (dv_cnt !== exp_dv) begin miscompares++; $display("FAIL handshake dv_count: got %0d expected %0d", dv_cnt, exp_dv); end
   endtask

   task automatic test_full_dump();
      rand_dump();
      dump_w[0]      = 32'h1ba5e93f;
      dump_w[DW - 1] = 32'hdeadbeef;
      issue_cmd();
      send_bytes(0, DW * BPW - 1);
      vectors++; if (dump_valid !== 1'b0) begin miscompares++; $display("FAIL early dump_valid: got %b expected 0", dump_valid); end
      send_bytes(DW * BPW - 1, 1);
      exp_dv++;
      model_words(DW);
      vectors++; if (dump_valid !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL done pulse: got dv=%b busy=%b expected 1 1", dump_valid, busy); end
      step();
      vectors++; if (dump_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL after done: got dv=%b busy=%b expected 0 0", dump_valid, busy); end
      for (int i = 0; i < NIDX; i++) begin
         rd_index = IW'(i); #1;
         exp_w = (i < DW) ? exp_store[i] : '0;
         vectors++;
         if (rd_word !== exp_w) begin miscompares++; $display("FAIL full_dump rd[%0d]: got %h expected %h", i, rd_word, exp_w); end
      end
      vectors++; if (dv_cnt !== exp_dv) begin miscompares++; $display("FAIL full_dump dv_count: got %0d expected %0d", dv_cnt, exp_dv); end
   endtask

   task automatic test_stray_bytes();
      for (int i = 0; i < 3; i++) send_byte(DB'($urandom));
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stray idle busy: got %b expected 0", busy); end
      for (int i = 0; i < NIDX; i++) begin
         rd_index = IW'(i); #1;
         exp_w = (i < DW) ? exp_store[i] : '0;
         vectors++;
         if (rd_word !== exp_w) begin miscompares++; $display("FAIL stray_idle rd[%0d]: got %h expected %h", i, rd_word, exp_w); end
      end
      rand_dump();
      start = 1'b1; step(); start = 1'b0; exp_cmd++;
      send_byte(DB'($urandom));
      send_byte(DB'($urandom));
      vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL stray send tx_ready: got %b expected 1", tx_ready); end
      tx_done = 1'b1; step(); tx_done = 1'b0;
      send_bytes(0, DW * BPW);
      exp_dv++;
      model_words(DW);
      vectors++; if (dump_valid !== 1'b1) begin miscompares++; $display("FAIL stray dump_valid: got %b expected 1", dump_valid); end
      step(); step();
      for (int i = 0; i < NIDX; i++) begin
         rd_index = IW'(i); #1;
         exp_w = (i < DW) ? exp_store[i] : '0;
         vectors++;
         if (rd_word !== exp_w) begin miscompares++; $display("FAIL stray_dump rd[%0d]: got %h expected %h", i, rd_word, exp_w); end
      end
   endtask

   task automatic test_timeout();
      logic early;
      rand_dump();
      issue_cmd();
      send_bytes(0, BPW + 2);
      model_words(1);
      early = 1'b0;
      for (int k = 1; k < TO; k++) begin
         step();
         if (error !== 1'b0) early = 1'b1;
      end
      vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL timeout early error: got %b expected 0", early); end
      step();
      exp_err++;
      vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL timeout error: got %b expected 1", error); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout busy: got %b expected 0", busy); end
      step();
      vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL timeout pulse width: got %b expected 0", error); end
      for (int i = 0; i < NIDX; i++) begin
         rd_index = IW'(i); #1;
         exp_w = (i < DW) ? exp_store[i] : '0;
         vectors++;
         if (rd_word !== exp_w) begin miscompares++; $display("FAIL timeout rd[%0d]: got %h expected %h", i, rd_word, exp_w); end
      end
      vectors++; if (dv_cnt !== exp_dv || err_cnt !== exp_err) begin miscompares++; $display("FAIL timeout pulses: got dv=%0d err=%0d expected %0d %0d", dv_cnt, err_cnt, exp_dv, exp_err); end
   endtask

   task automatic test_reset_mid();
      rand_dump();
      issue_cmd();
      send_bytes(0, 9);
      #3 rst_n = 1'b0;
      #1;
      for (int k = 0; k < DW; k++) exp_store[k] = '0;
      vectors++; if (busy !== 1'b0 || tx_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got busy=%b ready=%b expected 0 0", busy, tx_ready); end
      for (int i = 0; i < NIDX; i++) begin
         rd_index = IW'(i); #1;
         vectors++;
         if (rd_word !== '0) begin miscompares++; $display("FAIL mid_reset rd[%0d]: got %h expected 0", i, rd_word); end
      end
      step(); step();
      rst_n = 1'b1;
      step();
      rand_dump();
      issue_cmd();
      send_bytes(0, DW * BPW);
      exp_dv++;
      model_words(DW);
      vectors++; if (dump_valid !== 1'b1) begin miscompares++; $display("FAIL post_reset dump_valid: got %b expected 1", dump_valid); end
      step(); step();
      for (int i = 0; i < NIDX; i++) begin
         rd_index = IW'(i); #1;
         exp_w = (i < DW) ? exp_store[i] : '0;
         vectors++;
         if (rd_word !== exp_w) begin miscompares++; $display("FAIL post_reset rd[%0d]: got %h expected %h", i, rd_word, exp_w); end
      end
      vectors++; if (dv_cnt !== exp_dv || err_cnt !== exp_err) begin miscompares++; $display("FAIL reset pulses: got dv=%0d err=%0d expected %0d %0d", dv_cnt, err_cnt, exp_dv, exp_err); end
   endtask

   task automatic test_back_to_back();
      rand_dump();
      issue_cmd();
      send_bytes(0, DW * BPW);
      exp_dv++;
      model_words(DW);
      step(); step();
      rand_dump();
      issue_cmd();
      send_bytes(0, 3 * BPW);
      model_words(3);
      for (int i = 0; i < NIDX; i++) begin
         rd_index = IW'(i); #1;
         exp_w = (i < DW) ? exp_store[i] : '0;
         vectors++;
         if (rd_word !== exp_w) begin miscompares++; $display("FAIL partial_overwrite rd[%0d]: got %h expected %h", i, rd_word, exp_w); end
      end
      send_bytes(3 * BPW, (DW - 3) * BPW);
      exp_dv++;
      model_words(DW);
      step(); step();
      for (int i = 0; i < NIDX; i++) begin
         rd_index = IW'(i); #1;
         exp_w = (i < DW) ? exp_store[i] : '0;
         vectors++;
         if (rd_word !== exp_w) begin miscompares++; $display("FAIL back_to_back rd[%0d]: got %h expected %h", i, rd_word, exp_w); end
      end
      vectors++; if (dv_cnt !== exp_dv) begin miscompares++; $display("FAIL final dv_count: got %0d expected %0d", dv_cnt, exp_dv); end
      vectors++; if (err_cnt !== exp_err) begin miscompares++; $display("FAIL final err_count: got %0d expected %0d", err_cnt, exp_err); end
      vectors++; if (cmd_cnt !== exp_cmd) begin miscompares++; $display("FAIL final cmd_count: got %0d expected %0d", cmd_cnt, exp_cmd); end
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      rx_ready = 1'b0;
      rx_data  = '0;
      tx_done  = 1'b0;
      rd_index = '0;
      test_reset();
      test_start_handshake();
      test_full_dump();
      test_stray_bytes();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

endmodule

// File: doc/debug_dump_receiver.md
# debug_dump_receiver

Host-side counterpart of the MIPS debug unit. It issues a step command byte over the UART transmit handshake, then collects the debug unit's reply stream: PC, then NUMBER_REGISTERS register words, then the ALU result, each sent as 4 bytes MSB-first. It reassembles the stream into a readable word store. It sits between a UART rx/tx pair and the on-board test controller (or a loopback bench), and flags completion or timeout.

## Interface
- NB, 32, word width; must be a multiple of DATA_BITS
- DATA_BITS, 8, UART byte width
- NUMBER_REGISTERS, 32, register words in one dump
- TIMEOUT_CYCLES, 1_000_000, max idle cycles between received bytes while collecting
- i_clk  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  request one step + dump; sampled only in IDLE
- i_uart_rx_ready  in  1  one-cycle pulse per received byte
- i_uart_rx_data  in  DATA_BITS  received byte, valid with rx_ready
- i_uart_tx_done  in  1  UART transmitter finished current byte
- o_uart_tx_data  out  DATA_BITS  byte to send
- o_uart_tx_ready  out  1  level; byte valid until tx_done seen
- i_rd_index  in  clog2(NUMBER_REGISTERS+2)  word index for readback (0 = PC, 1..N = regs, N+1 = ALU)
- o_rd_word  out  NB  stored word at i_rd_index; 0 if index out of range
- o_busy  out  1  high from accepted start until DONE or timeout
- o_dump_valid  out  1  one-cycle pulse: full dump stored
- o_error  out  1  one-cycle pulse: inter-byte timeout

## Operation
- States: IDLE, SEND_CMD, COLLECT, DONE.
- IDLE:
  - i_start=1 → SEND_CMD.
  - Load o_uart_tx_data=CMD_STEP (8'h73), clear byte/word counters.
  - Any rx bytes in IDLE are dropped.
- SEND_CMD:
  - o_uart_tx_ready=1 held with data 8'h73.
  - On i_uart_tx_done=1 → COLLECT, tx_ready drops, tx_data returns to 0.
  - rx bytes in SEND_CMD are dropped.
- COLLECT:
  - Each rx_ready pulse shifts the byte into the assembly register (MSB first) and increments byte_cnt (0..NB/DATA_BITS-1).
  - On the last byte of a word, the assembled word is written to store[word_cnt], word_cnt increments, byte_cnt wraps to 0.
  - After word NUMBER_REGISTERS+1 is written → DONE.
- DONE: one cycle; o_dump_valid=1, o_busy falls; → IDLE.
- Timeout:
  - idle_cnt counts cycles without rx_ready in COLLECT and clears on each byte.
  - Reaching TIMEOUT_CYCLES pulses o_error and returns to IDLE.
  - Words already stored are kept; a partial word is discarded; no dump_valid.
- i_start while busy is ignored. i_uart_tx_done outside SEND_CMD is ignored.
- A new dump overwrites the store word by word; the previous contents remain readable until overwritten.

## Timing
- Reset (async assert, i_reset=0):
  - state=IDLE; all counters 0; store cleared to 0.
  - o_uart_tx_data=0, o_uart_tx_ready=0, o_busy=0, o_dump_valid=0, o_error=0.
- Start accepted at edge T: tx_ready=1 and busy=1 from T+1.
- tx_done sampled high at edge T: tx_ready=0 from T+1; the first byte can be accepted at T+1.
- A word completed on the byte at edge T is readable on o_rd_word from T+1. Readback is a combinational read of the store.
- Final byte at edge T: o_dump_valid high during T+1 only, busy low from T+2.
- Reset asserted mid-dump aborts immediately with no pulse outputs.
- Timeout fires on the edge where idle_cnt reaches TIMEOUT_CYCLES; o_error is high for the following cycle.

## Structure
- Package debug_pkg:
  - CMD_STEP=8'h73
  - state encoding localparams
  - DUMP_WORDS = NUMBER_REGISTERS+2
  - BYTES_PER_WORD = NB/DATA_BITS
- Sub-module word_assembler:
  - Inputs: byte, byte_valid, clear.
  - Outputs: word, word_done pulse.
  - Holds the byte counter and shift register.
- The top holds the FSM, word counter, timeout counter and store.

## Test plan
- Reset: hold i_reset=0 with rx/tx activity → all outputs 0, o_rd_word=0 for every index.
- Start handshake: i_start pulse → next cycle tx_ready=1, tx_data=8'h73. tx_done pulse → tx_ready=0. A second i_start while busy → no second command.
- Full dump (NUMBER_REGISTERS=5): bytes for PC 0x1ba5e93f, five random regs, ALU 0xdeadbeef → o_dump_valid once. Index 0 reads 0x1ba5e93f, 1..5 read the regs, 6 reads 0xdeadbeef, 7 reads 0.
- Stray bytes: rx pulses during IDLE and SEND_CMD → ignored; store unchanged; byte alignment is correct afterwards.
- Timeout (TIMEOUT_CYCLES=50): send PC plus 2 bytes, then silence → o_error pulse 50 cycles after the last byte. Index 0 = PC; index 1 unchanged; busy=0.
- Reset mid-dump: assert i_reset=0 after 9 bytes → immediate IDLE, store=0. A following full dump then completes correctly.
